// File: rtl/rpms_pkg.sv
// rpms_pkg: shared session state encoding and datapath field widths for the run pipeline
package rpms_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    DONE  = 3'd4
  } state_t;
  localparam int HR_W = 8;
  localparam int STEPS_W = 3;
  localparam int STRIDE_W = 8;
  localparam int STEPS_MAX_D = 4;
endpackage

// File: rtl/sample_pacer.sv
// sample_pacer: sample-slot prescaler that can be cleared, frozen or advanced; flags the last tick of each slot
module sample_pacer #(
  parameter int TICKS_PER_SAMPLE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic sample_due
);
  localparam int W = $clog2(TICKS_PER_SAMPLE);
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SAMPLE - 1);
  logic [W-1:0] cnt;
  assign sample_due = cnt == LAST;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= sample_due ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/run_session_sequencer.sv
// run_session_sequencer: session FSM that paces, sanitises and holds samples for the step calculator.
// Optional zero-step auto-pause is built when RUN_SESSION_AUTOPAUSE_EN is defined.
module run_session_sequencer
  import rpms_pkg::*;
#(
  parameter int TICKS_PER_SAMPLE  = 4,
  parameter int MAX_SAMPLES       = 20,
  parameter int CLEAR_CYCLES      = 2,
  parameter int STEPS_MAX         = STEPS_MAX_D,
  parameter int AUTOPAUSE_SAMPLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                stop,
  input  logic [HR_W-1:0]     hr_in,
  input  logic [STEPS_W-1:0]  steps_in,
  input  logic [STRIDE_W-1:0] stride_in,
  output logic                dp_rst,
  output logic                valid_input,
  output logic [HR_W-1:0]     hr_input,
  output logic [STEPS_W-1:0]  steps_per_second,
  output logic [STRIDE_W-1:0] stride_length,
  output logic [2:0]          state_o,
  output logic                busy,
  output logic                done,
  output logic [7:0]          sample_count,
  output logic [7:0]          dropout_count
`ifdef RUN_SESSION_AUTOPAUSE_EN
  ,
  output logic                autopaused
`endif
);
  state_t state, state_n;
  logic [7:0] clr_cnt;
  logic due, run_en, accept, drop, last, zero_hit, clr_entry;
  logic [STEPS_W-1:0] steps_c;
  sample_pacer #(.TICKS_PER_SAMPLE(TICKS_PER_SAMPLE)) u_pacer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state == CLEAR),
    .en        (run_en),
    .sample_due(due)
  );
  assign steps_c   = (steps_in > STEPS_W'(STEPS_MAX)) ? STEPS_W'(STEPS_MAX) : steps_in;
  assign run_en    = state == RUN && !stop && !pause;
  assign accept    = run_en && due && hr_in != '0;
  assign drop      = run_en && due && hr_in == '0;
  assign last      = accept && sample_count == 8'(MAX_SAMPLES - 1);
  assign clr_entry = state != CLEAR && state_n == CLEAR;
  assign state_o   = state;
  assign dp_rst    = state == CLEAR;
  assign busy      = state == CLEAR || state == RUN || state == PAUSE;
  assign done      = state == DONE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start ? CLEAR : IDLE;
      CLEAR:   state_n = clr_cnt == 8'(CLEAR_CYCLES - 1) ? RUN : CLEAR;
      RUN:     state_n = stop ? DONE : pause ? PAUSE : last ? DONE : zero_hit ? PAUSE : RUN;
      PAUSE:   state_n = stop ? DONE : start ? RUN : PAUSE;
      DONE:    state_n = start ? CLEAR : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      clr_cnt          <= '0;
      valid_input      <= 1'b0;
      hr_input         <= '0;
      steps_per_second <= '0;
      stride_length    <= '0;
      sample_count     <= '0;
      dropout_count    <= '0;
    end else begin
      state       <= state_n;
      clr_cnt     <= state == CLEAR ? clr_cnt + 8'd1 : '0;
      valid_input <= accept;
      if (accept) begin
        hr_input         <= hr_in;
        steps_per_second <= steps_c;
        stride_length    <= stride_in;
        sample_count     <= sample_count + 8'd1;
      end
      if (drop && dropout_count != 8'hff) dropout_count <= dropout_count + 8'd1;
      if (clr_entry) begin
        sample_count  <= '0;
        dropout_count <= '0;
      end
    end
  end
`ifdef RUN_SESSION_AUTOPAUSE_EN
  logic [7:0] zero_cnt;
  assign zero_hit = accept && steps_c == '0 && zero_cnt == 8'(AUTOPAUSE_SAMPLES - 1);
  always_ff @(posedge clk) begin
    if (rst || clr_entry || (state == PAUSE && state_n == RUN)) zero_cnt <= '0;
    else if (accept) zero_cnt <= steps_c == '0 ? zero_cnt + 8'd1 : '0;
    // From RUN, a PAUSE next-state without the pause command can only come from the zero-step run
    if (rst) autopaused <= 1'b0;
    else autopaused <= state_n == PAUSE && (state == PAUSE ? autopaused : state == RUN && !pause);
  end
`else
  assign zero_hit = 1'b0;
`endif
endmodule

// File: tb/tb_run_session_sequencer.sv
// tb_run_session_sequencer: directed self-checking bench for run_session_sequencer with default parameters
module tb_run_session_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [7:0] hr_in = '0, stride_in = '0;
  logic [2:0] steps_in = '0;
  logic dp_rst, valid_input, busy, done;
  logic [7:0] hr_input, stride_length, sample_count, dropout_count;
  logic [2:0] steps_per_second, state_o;
  int checks = 0, failures = 0;
`ifdef RUN_SESSION_AUTOPAUSE_EN
  logic autopaused;
`endif
  run_session_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
    .hr_in(hr_in), .steps_in(steps_in), .stride_in(stride_in),
    .dp_rst(dp_rst), .valid_input(valid_input), .hr_input(hr_input),
    .steps_per_second(steps_per_second), .stride_length(stride_length),
    .state_o(state_o), .busy(busy), .done(done),
    .sample_count(sample_count), .dropout_count(dropout_count)
`ifdef RUN_SESSION_AUTOPAUSE_EN
    , .autopaused(autopaused)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_session();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("clear_state", state_o, 1);
    chk("clear_dp_rst1", dp_rst, 1);
    step();
    chk("clear_dp_rst2", dp_rst, 1);
    step();
    chk("run_entry", state_o, 2);
    chk("run_dp_rst", dp_rst, 0);
  endtask
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!valid_input && n < 16);
    if (!valid_input) chk("strobe_timeout", valid_input, 1);
  endtask
  initial begin
    int n, nv;
    logic [2:0] es;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_state", state_o, 0);
    chk("rst_valid", valid_input, 0);
    chk("rst_dp_rst", dp_rst, 0);
    chk("rst_busy", busy, 0);
    chk("rst_hr", hr_input, 0);
    chk("rst_count", sample_count, 0);
    pause = 1'b1; stop = 1'b1;
    step();
    pause = 1'b0; stop = 1'b0;
    chk("idle_ignore", state_o, 0);
    // Session 1: full 20-sample run with clamp cases at samples 5 and 6
    hr_in = 8'd110; steps_in = 3'd3; stride_in = 8'd75;
    start_session();
    for (int k = 0; k < 20; k++) begin
      nv = 0;
      steps_in = k == 5 ? 3'd6 : k == 6 ? 3'd0 : 3'd3;
      es = k == 5 ? 3'd4 : k == 6 ? 3'd0 : 3'd3;
      for (int j = 0; j < 3; j++) begin
        step();
        nv += int'(valid_input);
      end
      step();
      chk("gap_quiet", nv, 0);
      chk("strobe", valid_input, 1);
      chk("hr_out", hr_input, 110);
      chk("steps_out", steps_per_second, es);
      chk("stride_out", stride_length, 75);
    end
    chk("max_done", done, 1);
    chk("max_count", sample_count, 20);
    step();
    chk("done_no_strobe", valid_input, 0);
    step(); step(); step(); step();
    chk("done_hold_count", sample_count, 20);
    chk("done_hold_hr", hr_input, 110);
    // Session 2: dropout slots, then pause/resume, then start+stop in PAUSE
    hr_in = 8'd90; steps_in = 3'd2; stride_in = 8'd60;
    start_session();
    chk("restart_count", sample_count, 0);
    wait_strobe(n);
    chk("first_latency", n, 4);
    wait_strobe(n);
    hr_in = 8'd0;
    nv = 0;
    for (int j = 0; j < 12; j++) begin
      step();
      nv += int'(valid_input);
    end
    chk("dropout_quiet", nv, 0);
    chk("dropout_count", dropout_count, 3);
    chk("dropout_samples", sample_count, 2);
    chk("dropout_hold_hr", hr_input, 90);
    hr_in = 8'd95;
    wait_strobe(n);
    chk("post_dropout_latency", n, 4);
    chk("post_dropout_hr", hr_input, 95);
    step(); step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    chk("paused_state", state_o, 3);
    nv = 0;
    for (int j = 0; j < 9; j++) begin
      step();
      nv += int'(valid_input);
    end
    chk("pause_quiet", nv, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("resume_state", state_o, 2);
    chk("resume_no_strobe0", valid_input, 0);
    step();
    chk("resume_no_strobe1", valid_input, 0);
    step();
    chk("resume_strobe", valid_input, 1);
    chk("resume_count", sample_count, 4);
    pause = 1'b1;
    step();
    pause = 1'b0;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("stop_beats_start", state_o, 4);
    chk("stop_busy", busy, 0);
    // Session 3: stop lands on the sample_due cycle
    start_session();
    wait_strobe(n);
    step(); step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_state", state_o, 4);
    chk("stop_no_strobe", valid_input, 0);
    chk("stop_count", sample_count, 1);
    step();
    chk("stop_quiet", valid_input, 0);
    // Session 4: reset on a sample_due cycle
    start_session();
    wait_strobe(n);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_state", state_o, 0);
    chk("mid_rst_valid", valid_input, 0);
    chk("mid_rst_hr", hr_input, 0);
    chk("mid_rst_steps", steps_per_second, 0);
    chk("mid_rst_stride", stride_length, 0);
    chk("mid_rst_count", sample_count, 0);
    chk("mid_rst_busy", busy, 0);
`ifdef RUN_SESSION_AUTOPAUSE_EN
    hr_in = 8'd100; steps_in = 3'd0;
    start_session();
    wait_strobe(n);
    wait_strobe(n);
    chk("ap_still_run", state_o, 2);
    wait_strobe(n);
    chk("ap_strobe", valid_input, 1);
    chk("ap_state", state_o, 3);
    chk("ap_flag", autopaused, 1);
    step();
    chk("ap_quiet", valid_input, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ap_resume", state_o, 2);
    chk("ap_flag_clr", autopaused, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/run_session_sequencer.md
Name: run_session_sequencer

Overview:
- Session controller in front of one StepCalculatorDataflow instance; one sequencer per run.
- Owns the session lifecycle: clear, run, pause, stop, done.
- Paces the datapath by issuing one-cycle valid_input strobes at a fixed sample rate.
- Registers, sanitises and holds hr/steps/stride stable for the datapath. Gates out samples during sensor dropout.

Parameters:
TICKS_PER_SAMPLE, 4, clk cycles per sample slot (≥2); 1 s of real time in silicon builds
MAX_SAMPLES, 20, session auto-ends after this many accepted samples (1..255)
CLEAR_CYCLES, 2, cycles dp_rst is held high on session start (≥1)
STEPS_MAX, 4, steps_per_second clamp ceiling
AUTOPAUSE_SAMPLES, 3, consecutive zero-step samples before auto-pause (AUTO_PAUSE_EN only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse; IDLE/DONE: begin new session; PAUSE: resume
pause  in  1  pulse; RUN→PAUSE
stop  in  1  pulse; RUN/PAUSE→DONE
hr_in  in  8  raw heart-rate sensor; 0 = dropout
steps_in  in  3  raw steps per second
stride_in  in  8  stride length, cm
dp_rst  out  1  datapath clear, to calculator rst (OR'd with rst externally)
valid_input  out  1  one-cycle sample strobe to calculator
hr_input  out  8  registered HR to calculator
steps_per_second  out  3  registered, clamped steps
stride_length  out  8  registered stride
state_o  out  3  IDLE=0, CLEAR=1, RUN=2, PAUSE=3, DONE=4
busy  out  1  state is CLEAR, RUN or PAUSE
done  out  1  state is DONE
sample_count  out  8  accepted samples this session
dropout_count  out  8  skipped (hr_in==0) slots; saturates at 255

Behaviour:
- Reset (synchronous): state IDLE; every output 0; prescaler, clear counter and zero-step counter 0. Reset mid-session aborts to IDLE immediately, with no valid strobe in that cycle.
- IDLE:
  - start → CLEAR.
  - pause/stop ignored.
- CLEAR:
  - dp_rst=1 for exactly CLEAR_CYCLES cycles, then RUN.
  - On CLEAR entry, sample_count, dropout_count and prescaler are zeroed.
  - All commands are ignored.
- RUN:
  - Prescaler counts 0..TICKS_PER_SAMPLE-1 and wraps. sample_due = (prescaler==TICKS_PER_SAMPLE-1).
  - First strobe is TICKS_PER_SAMPLE cycles after RUN entry.
- On sample_due with no stop/pause that cycle:
  - If hr_in≠0, at the same edge register hr_input=hr_in, steps_per_second=min(steps_in,STEPS_MAX), stride_length=stride_in, and pulse valid_input=1. Data and strobe therefore appear together for 1 cycle. sample_count+1.
  - If hr_in==0, there is no strobe and the held outputs are unchanged. dropout_count+1 (saturating).
- Accepting sample number MAX_SAMPLES → DONE in the same edge. That final strobe is still issued.
- Command priority in RUN: stop > pause > sample_due.
  - stop → DONE with no strobe, even if sample_due.
  - pause → PAUSE with no strobe. Prescaler is frozen, not cleared.
- PAUSE:
  - Prescaler frozen; valid_input=0; held data outputs unchanged.
  - start → RUN, resuming the prescaler value.
  - stop → DONE. If start and stop arrive together, stop wins.
- DONE:
  - done=1; all counters and held outputs frozen, so calculator results stay readable.
  - start → CLEAR.
- valid_input is never high outside RUN, nor in two consecutive cycles.
- Counters are 8-bit. sample_count cannot exceed MAX_SAMPLES.

Optional Feature:
- Macro: RUN_SESSION_AUTOPAUSE_EN.
- Defined:
  - Accepted samples with clamped steps==0 increment the zero-step counter; any nonzero-step sample clears it.
  - When the counter reaches AUTOPAUSE_SAMPLES, go to PAUSE in the same edge, after that sample's strobe.
  - Resuming via start clears the counter.
  - Extra output autopaused (1 bit) is high while in PAUSE entered this way.
- Undefined: zero-step samples are ordinary samples; the autopaused port does not exist.

Decomposition:
- Shared package rpms_pkg holds the state encoding constants (IDLE..DONE), the STEPS_MAX default, and the HR/steps/stride width constants also used by the calculator and comparator.
- One sub-module is natural: sample_pacer (prescaler with enable/freeze/clear, outputs sample_due).
- FSM, sanitisation and counters stay in the top.

Test Plan:
- rst, start at cycle 0, hr_in=110, steps_in=3, stride_in=75, default params:
  - dp_rst high cycles 1–2; RUN at 3.
  - valid_input pulses every 4 cycles with outputs 110/3/75.
  - After 20 strobes, done=1 and sample_count=20.
- steps_in=6 → steps_per_second=4 at the strobe. steps_in=0 → 0.
- hr_in=0 for 3 slots mid-run:
  - no strobes in those slots; dropout_count=3; sample_count unchanged.
  - hr_input keeps its last value.
- pause at prescaler=2, then start 10 cycles later → next strobe exactly 2 cycles after resume; no strobe while paused.
- stop asserted in the same cycle as sample_due → no strobe; DONE next; sample_count unchanged.
- rst mid-RUN → state_o=0, all outputs 0 next cycle. With RUN_SESSION_AUTOPAUSE_EN: three steps_in=0 samples → PAUSE and autopaused=1 after the third strobe.
